// File: rtl/id_ex_hazard_latch_pkg.sv
// Shared widths, control-field bit positions and action encoding for the
// ID/EX pipeline register with load-use hazard detection.
package id_ex_hazard_latch_pkg;

  // Default widths of the pipeline datapath.
  localparam int NB_REG  = 5;
  localparam int NB_DATA = 32;
  localparam int NB_CTRL = 12;

  // Bit positions of the packed EX/MEM/WB control word.
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_BRANCH     = 8;
  localparam int CTRL_MEM_TO_REG = 9;
  localparam int CTRL_REG_WRITE  = 10;
  localparam int CTRL_JUMP_LINK  = 11;

  // What the pipeline register does on the next clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2
  } latch_act_e;

endpackage

// File: rtl/id_ex_hazard_latch_if.sv
// ID-stage inputs and EX-stage outputs of the ID/EX pipeline register.
// master = decode side that drives the ID fields, slave = the latch itself.
interface id_ex_hazard_latch_if #(
  parameter int NB_REG  = id_ex_hazard_latch_pkg::NB_REG,
  parameter int NB_DATA = id_ex_hazard_latch_pkg::NB_DATA,
  parameter int NB_CTRL = id_ex_hazard_latch_pkg::NB_CTRL
);
  logic               i_enable;
  logic               i_flush;
  logic [NB_REG-1:0]  i_if_id_rs;
  logic [NB_REG-1:0]  i_if_id_rt;
  logic [NB_REG-1:0]  i_if_id_rd;
  logic [NB_DATA-1:0] i_rs_data;
  logic [NB_DATA-1:0] i_rt_data;
  logic [NB_DATA-1:0] i_imm;
  logic [NB_CTRL-1:0] i_ctrl;
  logic               i_wr_en;
  logic               i_mem_rd_en;

  logic [NB_REG-1:0]  o_id_ex_rs;
  logic [NB_REG-1:0]  o_id_ex_rt;
  logic [NB_REG-1:0]  o_id_ex_rd;
  logic [NB_DATA-1:0] o_rs_data;
  logic [NB_DATA-1:0] o_rt_data;
  logic [NB_DATA-1:0] o_imm;
  logic [NB_CTRL-1:0] o_ctrl;
  logic               o_wr_en;
  logic               o_mem_rd_en;
  logic               o_stall;
  logic [NB_DATA-1:0] o_stall_count;

  modport master (
    output i_enable, i_flush, i_if_id_rs, i_if_id_rt, i_if_id_rd,
           i_rs_data, i_rt_data, i_imm, i_ctrl, i_wr_en, i_mem_rd_en,
    input  o_id_ex_rs, o_id_ex_rt, o_id_ex_rd, o_rs_data, o_rt_data,
           o_imm, o_ctrl, o_wr_en, o_mem_rd_en, o_stall, o_stall_count
  );

  modport slave (
    input  i_enable, i_flush, i_if_id_rs, i_if_id_rt, i_if_id_rd,
           i_rs_data, i_rt_data, i_imm, i_ctrl, i_wr_en, i_mem_rd_en,
    output o_id_ex_rs, o_id_ex_rt, o_id_ex_rd, o_rs_data, o_rt_data,
           o_imm, o_ctrl, o_wr_en, o_mem_rd_en, o_stall, o_stall_count
  );
endinterface

// File: rtl/id_ex_hazard_latch_hazard_detect_unit.sv
// Purely combinational load-use hazard detector. A load sitting in EX whose
// destination (rt, never r0) is read by the instruction in ID forces a stall,
// unless that ID instruction is being flushed anyway.
module hazard_detect_unit #(
  parameter int NB_REG = id_ex_hazard_latch_pkg::NB_REG
) (
  input  logic              i_ex_mem_rd_en,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_flush,
  output logic              o_stall
);
  logic w_hazard;

  assign w_hazard = i_ex_mem_rd_en
                  && (i_ex_rt != {NB_REG{1'b0}})
                  && ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  assign o_stall = w_hazard && !i_flush;
endmodule

// File: rtl/id_ex_hazard_latch.sv
// ID/EX pipeline register with load-use stall, branch flush, debug-step
// enable and a saturating stall-cycle counter. All state lives here; the
// hazard decision comes from hazard_detect_unit.
module id_ex_hazard_latch
  import id_ex_hazard_latch_pkg::*;
#(
  parameter int NB_REG  = id_ex_hazard_latch_pkg::NB_REG,
  parameter int NB_DATA = id_ex_hazard_latch_pkg::NB_DATA,
  parameter int NB_CTRL = id_ex_hazard_latch_pkg::NB_CTRL
) (
  input logic                 i_clock,
  input logic                 i_reset,
  id_ex_hazard_latch_if.slave bus
);
  logic [NB_REG-1:0]  r_id_ex_rs;
  logic [NB_REG-1:0]  r_id_ex_rt;
  logic [NB_REG-1:0]  r_id_ex_rd;
  logic [NB_DATA-1:0] r_rs_data;
  logic [NB_DATA-1:0] r_rt_data;
  logic [NB_DATA-1:0] r_imm;
  logic [NB_CTRL-1:0] r_ctrl;
  logic               r_wr_en;
  logic               r_mem_rd_en;
  logic [NB_DATA-1:0] r_stall_count;
  logic               w_stall;
  latch_act_e         w_act;

  hazard_detect_unit #(.NB_REG(NB_REG)) u_hazard (
    .i_ex_mem_rd_en (r_mem_rd_en),
    .i_ex_rt        (r_id_ex_rt),
    .i_id_rs        (bus.i_if_id_rs),
    .i_id_rt        (bus.i_if_id_rt),
    .i_flush        (bus.i_flush),
    .o_stall        (w_stall)
  );

  // Choose hold, bubble (flush or stall) or capture for the next edge.
  always_comb begin
    w_act = ACT_HOLD;
    if (!bus.i_enable) begin
      w_act = ACT_HOLD;
    end else if (bus.i_flush || w_stall) begin
      w_act = ACT_BUBBLE;
    end else begin
      w_act = ACT_LOAD;
    end
  end

  // Pipeline register: bubble clears everything, load captures the ID fields.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_id_ex_rs  <= '0;
      r_id_ex_rt  <= '0;
      r_id_ex_rd  <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_ctrl      <= '0;
      r_wr_en     <= 1'b0;
      r_mem_rd_en <= 1'b0;
    end else begin
      case (w_act)
        ACT_BUBBLE: begin
          r_id_ex_rs  <= '0;
          r_id_ex_rt  <= '0;
          r_id_ex_rd  <= '0;
          r_rs_data   <= '0;
          r_rt_data   <= '0;
          r_imm       <= '0;
          r_ctrl      <= '0;
          r_wr_en     <= 1'b0;
          r_mem_rd_en <= 1'b0;
        end
        ACT_LOAD: begin
          r_id_ex_rs  <= bus.i_if_id_rs;
          r_id_ex_rt  <= bus.i_if_id_rt;
          r_id_ex_rd  <= bus.i_if_id_rd;
          r_rs_data   <= bus.i_rs_data;
          r_rt_data   <= bus.i_rt_data;
          r_imm       <= bus.i_imm;
          r_ctrl      <= bus.i_ctrl;
          r_wr_en     <= bus.i_wr_en;
          r_mem_rd_en <= bus.i_mem_rd_en;
        end
        default: begin
          r_id_ex_rs  <= r_id_ex_rs;
          r_id_ex_rt  <= r_id_ex_rt;
          r_id_ex_rd  <= r_id_ex_rd;
          r_rs_data   <= r_rs_data;
          r_rt_data   <= r_rt_data;
          r_imm       <= r_imm;
          r_ctrl      <= r_ctrl;
          r_wr_en     <= r_wr_en;
          r_mem_rd_en <= r_mem_rd_en;
        end
      endcase
    end
  end

  // Count enabled stall cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_count <= '0;
    end else if (bus.i_enable && w_stall && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + {{(NB_DATA-1){1'b0}}, 1'b1};
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

  assign bus.o_id_ex_rs    = r_id_ex_rs;
  assign bus.o_id_ex_rt    = r_id_ex_rt;
  assign bus.o_id_ex_rd    = r_id_ex_rd;
  assign bus.o_rs_data     = r_rs_data;
  assign bus.o_rt_data     = r_rt_data;
  assign bus.o_imm         = r_imm;
  assign bus.o_ctrl        = r_ctrl;
  assign bus.o_wr_en       = r_wr_en;
  assign bus.o_mem_rd_en   = r_mem_rd_en;
  assign bus.o_stall       = w_stall;
  assign bus.o_stall_count = r_stall_count;
endmodule

// File: doc/id_ex_hazard_latch.md
ID_EX_HAZARD_LATCH -- requirements
Module: id_ex_hazard_latch

Interface
REQ-001 Parameter NB_REG, default `NB_REG (5): register-index width.
REQ-002 Parameter NB_DATA, default 32: datapath width.
REQ-003 Parameter NB_CTRL, default 12: packed EX/MEM/WB control width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 i_clock  in  1  rising-edge clock.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_enable  in  1  pipeline advance enable (debug step); 0 = hold all state.
REQ-008 i_flush  in  1  squash the ID instruction (branch/jump taken).
REQ-009 i_if_id_rs, i_if_id_rt, i_if_id_rd  in  NB_REG each  ID-stage register indices.
REQ-010 i_rs_data, i_rt_data, i_imm  in  NB_DATA each  register-file read data and sign-extended immediate.
REQ-011 i_ctrl  in  NB_CTRL  decoded control; i_wr_en, i_mem_rd_en  in  1 each  register write and load flags.
REQ-012 o_id_ex_rs, o_id_ex_rt, o_id_ex_rd  out  NB_REG each  latched indices (to the forwarding unit).
REQ-013 o_rs_data, o_rt_data, o_imm  out  NB_DATA each; o_ctrl  out  NB_CTRL; o_wr_en, o_mem_rd_en  out  1 each.
REQ-014 o_stall  out  1  load-use hazard; holds PC and IF/ID.
REQ-015 o_stall_count  out  NB_DATA  saturating count of stall cycles.

Function
REQ-016 Load-use hazard (comb.): o_mem_rd_en=1, o_id_ex_rt!=0, and o_id_ex_rt equals i_if_id_rs or i_if_id_rt.
REQ-017 o_stall SHALL equal hazard AND NOT i_flush, combinationally, independent of i_enable.
REQ-018 On a clock edge with i_enable=0, every register SHALL hold its value.
REQ-019 On a clock edge with i_enable=1, the priority SHALL be flush > stall > load.
REQ-020 Flush or stall SHALL insert a bubble: o_ctrl, o_wr_en, o_mem_rd_en <= 0; indices <= 0; data and immediate <= 0.
REQ-021 Load SHALL capture all i_* fields into their o_* counterparts; latency exactly one cycle.
REQ-022 o_stall_count SHALL increment by 1 on each enabled edge with o_stall=1; it saturates at all-ones and never wraps.
REQ-023 A bubble has o_mem_rd_en=0, so a stall SHALL last exactly one cycle per load.
REQ-024 Flush and hazard together: bubble inserted, o_stall=0, counter unchanged.

Reset
REQ-025 i_reset=0 SHALL asynchronously clear all outputs, including o_stall_count, to 0; o_stall is therefore 0.
REQ-026 Reset asserted mid-stall SHALL cancel the stall immediately; the first enabled edge after release performs a normal load.

Structure
REQ-027 NB_REG, NB_DATA, NB_CTRL and the control-field bit positions SHALL reside in the shared include file.
REQ-028 Hazard detection SHALL be a sub-module, hazard_detect_unit, that is purely combinational; this block owns all state.

Verification
REQ-029 Load r5 in EX (o_id_ex_rt=5, o_mem_rd_en=1), ID reads rs=5 -> o_stall=1; next edge gives o_ctrl=0 and o_stall_count=1; the following cycle o_stall=0.
REQ-030 Load with o_id_ex_rt=0, ID rs=0 -> o_stall=0; normal load; counter unchanged.
REQ-031 Hazard present and i_flush=1 -> o_stall=0; bubble; counter unchanged.
REQ-032 i_enable=0 for 3 cycles during a hazard -> outputs frozen, o_stall stays 1, counter unchanged.
REQ-033 Counter preset near saturation, then repeated hazards -> counter reaches and stays at 0xFFFFFFFF.
REQ-034 i_reset pulsed low between clock edges mid-stall -> all outputs 0 immediately; next enabled edge latches i_rs_data=0xDEADBEEF.
